// File: rtl/usb_jtag_pkg.sv
// Shared types and default parameters for the USB-JTAG transmit arbiter.
package usb_jtag_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} txState_e;

  localparam int DEF_NREQ       = 2;
  localparam int DEF_TIMEOUT    = 65535;
  localparam int DEF_TOW        = 16;
  localparam int DEF_GAP_CYCLES = 4;
endpackage

// File: rtl/usb_jtag_rr_pick.sv
// Combinational round-robin pick: lowest request at or above ptr, else lowest overall.
module usb_jtag_rr_pick
  import usb_jtag_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int OW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [OW-1:0]   idx,
  output logic            any
);
  logic [NREQ-1:0] masked;

  always_comb begin
    masked = '0;
    for (int i = 0; i < NREQ; i++) masked[i] = req[i] && (i >= int'(ptr));
    grant = '0;
    idx   = '0;
    // Scan high to low so the lowest set bit is the one left standing;
    // the masked pass overrides the wrap-around pass.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant = NREQ'(1) << i;
        idx   = OW'(i);
      end
    end
    if (|masked) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (masked[i]) begin
          grant = NREQ'(1) << i;
          idx   = OW'(i);
        end
      end
    end
    any = |req;
  end
endmodule

// File: rtl/usb_jtag_tx_arbiter.sv
// Round-robin arbiter and start/done sequencer for the byte-wide JTAG transmit channel.
module usb_jtag_tx_arbiter
  import usb_jtag_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TOW        = DEF_TOW,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                      iCLK,
  input  logic                      iRST_n,
  input  logic [NREQ-1:0]           iReq,
  input  logic [8*NREQ-1:0]         iData,
  output logic [NREQ-1:0]           oAck,
  output logic                      oErr,
  output logic [7:0]                oTxD_DATA,
  output logic                      oTxD_Start,
  input  logic                      iTxD_Done,
  output logic                      oBusy,
  output logic [$clog2(NREQ)-1:0]   oOwner
);
  localparam int OW = $clog2(NREQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  txState_e        state;
  logic [OW-1:0]   ptr;       // where the next search starts
  logic [TOW-1:0]  toCnt;
  logic [GW-1:0]   gapCnt;
  logic [NREQ-1:0] ownerGnt;

  logic [NREQ-1:0] pickGnt;
  logic [OW-1:0]   pickIdx;
  logic            pickAny;
  logic [OW-1:0]   ptrNext;

  usb_jtag_rr_pick #(.NREQ(NREQ)) uPick (
    .req   (iReq),
    .ptr   (ptr),
    .grant (pickGnt),
    .idx   (pickIdx),
    .any   (pickAny)
  );

  assign ptrNext = (int'(pickIdx) == NREQ - 1) ? '0 : pickIdx + 1'b1;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state      <= IDLE;
      ptr        <= '0;
      toCnt      <= '0;
      gapCnt     <= '0;
      ownerGnt   <= '0;
      oAck       <= '0;
      oErr       <= 1'b0;
      oTxD_DATA  <= '0;
      oTxD_Start <= 1'b0;
      oBusy      <= 1'b0;
      oOwner     <= '0;
    end else begin
      oAck <= '0;
      oErr <= 1'b0;
      case (state)
        IDLE: begin
          if (pickAny) begin
            state      <= SEND;
            oTxD_DATA  <= iData[{pickIdx, 3'b000} +: 8];
            oOwner     <= pickIdx;
            ownerGnt   <= pickGnt;
            ptr        <= ptrNext;
            toCnt      <= '0;
            oTxD_Start <= 1'b1;
            oBusy      <= 1'b1;
          end
        end
        SEND: begin
          toCnt <= toCnt + 1'b1;
          // Done beats a simultaneous timeout, so oErr only flags a true stall.
          if (iTxD_Done || toCnt == TOW'(TIMEOUT - 1)) begin
            state      <= GAP;
            gapCnt     <= '0;
            oAck       <= ownerGnt;
            oErr       <= !iTxD_Done;
            oTxD_Start <= 1'b0;
          end
        end
        GAP: begin
          if (gapCnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            oBusy <= 1'b0;
          end else begin
            gapCnt <= gapCnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          oTxD_Start <= 1'b0;
          oBusy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_usb_jtag_tx_arbiter.sv
// Scenario and randomized checks of the transmit arbiter against a behavioural round-robin model.
module tb_usb_jtag_tx_arbiter;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 100;
  localparam int TOW     = 16;
  localparam int GAPC    = 4;
  localparam int OW      = $clog2(NREQ);

  logic              iCLK, iRST_n;
  logic [NREQ-1:0]   iReq;
  logic [8*NREQ-1:0] iData;
  logic [NREQ-1:0]   oAck;
  logic              oErr;
  logic [7:0]        oTxD_DATA;
  logic              oTxD_Start;
  logic              iTxD_Done;
  logic              oBusy;
  logic [OW-1:0]     oOwner;

  int total, bad;
  int mPtr;                 // model: index where the next search starts
  logic [7:0] dat [NREQ];   // per-requester byte currently presented

  usb_jtag_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TOW(TOW), .GAP_CYCLES(GAPC)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iReq(iReq), .iData(iData), .oAck(oAck), .oErr(oErr),
    .oTxD_DATA(oTxD_DATA), .oTxD_Start(oTxD_Start), .iTxD_Done(iTxD_Done),
    .oBusy(oBusy), .oOwner(oOwner)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic int rrPick(input logic [NREQ-1:0] r, input int start);
    rrPick = -1;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int k;
      k = (start + i) % NREQ;
      if (r[k]) rrPick = k;
    end
  endfunction

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive_data();
    for (int k = 0; k < NREQ; k++) iData[8*k +: 8] = dat[k];
  endtask

  task automatic test_reset();
    iRST_n = 1'b0; iReq = '0; iData = '0; iTxD_Done = 1'b0;
    for (int k = 0; k < NREQ; k++) dat[k] = 8'h00;
    repeat (2) step();
    total++; if (oTxD_Start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", oTxD_Start); end
    total++; if (oAck !== '0) begin bad++; $display("FAIL reset_ack got=%b exp=0", oAck); end
    total++; if (oErr !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", oErr); end
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", oBusy); end
    total++; if (oOwner !== '0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", oOwner); end
    total++; if (oTxD_DATA !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", oTxD_DATA); end
    iRST_n = 1'b1;
    mPtr = 0;
    step();
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", oBusy); end
  endtask

  task automatic test_contention();
    logic [7:0] expB;
    dat[0] = 8'h11; dat[1] = 8'h22; drive_data();
    iReq = 2'b11;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) step(); else repeat (GAPC + 1) step();
      expB = (t % 2 == 1) ? 8'h22 : 8'h11;
      total++; if (oOwner !== OW'(t % 2)) begin bad++; $display("FAIL cont_owner%0d got=%0d exp=%0d", t, oOwner, t % 2); end
      total++; if (oTxD_DATA !== expB) begin bad++; $display("FAIL cont_data%0d got=%h exp=%h", t, oTxD_DATA, expB); end
      mPtr = (t % 2 + 1) % NREQ;
      repeat (5) step();
      iTxD_Done = 1'b1; step(); iTxD_Done = 1'b0;
      total++; if (oAck !== (NREQ'(1) << (t % 2))) begin bad++; $display("FAIL cont_ack%0d got=%b exp=%b", t, oAck, NREQ'(1) << (t % 2)); end
    end
    iReq = '0;
    repeat (GAPC + 1) step();
  endtask

  task automatic test_single();
    dat[0] = 8'h5A; drive_data();
    iReq = 2'b01;
    step();
    total++; if (oTxD_Start !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", oTxD_Start); end
    total++; if (oTxD_DATA !== 8'h5A) begin bad++; $display("FAIL single_data got=%h exp=5a", oTxD_DATA); end
    total++; if (oOwner !== OW'(0)) begin bad++; $display("FAIL single_owner got=%0d exp=0", oOwner); end
    mPtr = 1;
    repeat (20) step();
    iTxD_Done = 1'b1; step(); iTxD_Done = 1'b0;
    total++; if (oAck !== 2'b01) begin bad++; $display("FAIL single_ack got=%b exp=01", oAck); end
    total++; if (oErr !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", oErr); end
    iReq = '0;
    for (int g = 0; g < GAPC; g++) begin
      total++; if (oTxD_Start !== 1'b0 || oBusy !== 1'b1) begin bad++; $display("FAIL single_gap%0d start=%b busy=%b exp start=0 busy=1", g, oTxD_Start, oBusy); end
      step();
    end
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", oBusy); end
  endtask

  task automatic test_timeout();
    dat[0] = 8'($urandom); drive_data();
    iReq = 2'b01;
    step();
    total++; if (oTxD_DATA !== dat[0]) begin bad++; $display("FAIL to_data got=%h exp=%h", oTxD_DATA, dat[0]); end
    repeat (TIMEOUT - 1) step();
    total++; if (oAck !== '0 || oTxD_Start !== 1'b1) begin bad++; $display("FAIL to_early ack=%b start=%b exp ack=0 start=1", oAck, oTxD_Start); end
    step();
    total++; if (oAck !== 2'b01) begin bad++; $display("FAIL to_ack got=%b exp=01", oAck); end
    total++; if (oErr !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", oErr); end
    total++; if (oTxD_Start !== 1'b0) begin bad++; $display("FAIL to_start got=%b exp=0", oTxD_Start); end
    mPtr = 1;
    step();
    dat[0] = 8'($urandom); drive_data();
    repeat (GAPC) step();
    total++; if (oTxD_Start !== 1'b1 || oTxD_DATA !== dat[0]) begin bad++; $display("FAIL to_next start=%b data=%h exp start=1 data=%h", oTxD_Start, oTxD_DATA, dat[0]); end
    repeat (2) step();
    iTxD_Done = 1'b1; step(); iTxD_Done = 1'b0;
    total++; if (oAck !== 2'b01 || oErr !== 1'b0) begin bad++; $display("FAIL to_next_ack ack=%b err=%b exp ack=01 err=0", oAck, oErr); end
    iReq = '0;
    repeat (GAPC + 1) step();
  endtask

  task automatic test_collision();
    int w;
    dat[1] = 8'h3C; drive_data();
    iReq = 2'b10;
    w = rrPick(iReq, mPtr); mPtr = (w + 1) % NREQ;
    step();
    total++; if (oOwner !== OW'(w)) begin bad++; $display("FAIL coll_owner got=%0d exp=%0d", oOwner, w); end
    repeat (TIMEOUT - 1) step();
    iTxD_Done = 1'b1; step(); iTxD_Done = 1'b0;
    total++; if (oAck !== 2'b10) begin bad++; $display("FAIL coll_ack got=%b exp=10", oAck); end
    total++; if (oErr !== 1'b0) begin bad++; $display("FAIL coll_err got=%b exp=0", oErr); end
    iReq = '0;
    repeat (GAPC + 1) step();
  endtask

  task automatic test_data_change();
    dat[0] = 8'hA5; drive_data();
    iReq = 2'b01;
    step();
    mPtr = 1;
    total++; if (oTxD_DATA !== 8'hA5) begin bad++; $display("FAIL chg_data0 got=%h exp=a5", oTxD_DATA); end
    repeat (3) step();
    dat[0] = 8'hFF; drive_data(); iReq = '0;
    repeat (5) step();
    total++; if (oTxD_DATA !== 8'hA5 || oTxD_Start !== 1'b1) begin bad++; $display("FAIL chg_hold data=%h start=%b exp data=a5 start=1", oTxD_DATA, oTxD_Start); end
    iTxD_Done = 1'b1; step(); iTxD_Done = 1'b0;
    total++; if (oAck !== 2'b01 || oErr !== 1'b0) begin bad++; $display("FAIL chg_ack ack=%b err=%b exp ack=01 err=0", oAck, oErr); end
    step();
    iTxD_Done = 1'b1; step(); iTxD_Done = 1'b0;
    total++; if (oAck !== '0 || oBusy !== 1'b1 || oTxD_Start !== 1'b0) begin bad++; $display("FAIL gap_stray ack=%b busy=%b start=%b exp 00/1/0", oAck, oBusy, oTxD_Start); end
    repeat (GAPC - 2) step();
    total++; if (oBusy !== 1'b0 || oTxD_Start !== 1'b0) begin bad++; $display("FAIL gap_end busy=%b start=%b exp 0/0", oBusy, oTxD_Start); end
    iTxD_Done = 1'b1; step(); iTxD_Done = 1'b0;
    total++; if (oAck !== '0 || oTxD_Start !== 1'b0 || oBusy !== 1'b0) begin bad++; $display("FAIL idle_stray ack=%b start=%b busy=%b exp 00/0/0", oAck, oTxD_Start, oBusy); end
  endtask

  task automatic test_reset_mid();
    logic ackSeen;
    dat[1] = 8'($urandom); drive_data();
    iReq = 2'b10;
    step();
    total++; if (oTxD_Start !== 1'b1 || oOwner !== OW'(1)) begin bad++; $display("FAIL rst_pre start=%b owner=%0d exp 1/1", oTxD_Start, oOwner); end
    repeat (5) step();
    iRST_n = 1'b0;
    #1;
    total++; if (oTxD_Start !== 1'b0 || oAck !== '0 || oErr !== 1'b0 || oBusy !== 1'b0 || oOwner !== '0 || oTxD_DATA !== 8'h00) begin
      bad++; $display("FAIL rst_mid start=%b ack=%b err=%b busy=%b owner=%0d data=%h exp all 0", oTxD_Start, oAck, oErr, oBusy, oOwner, oTxD_DATA);
    end
    ackSeen = 1'b0;
    repeat (2) begin step(); if (oAck !== '0) ackSeen = 1'b1; end
    total++; if (ackSeen !== 1'b0) begin bad++; $display("FAIL rst_noack got=%b exp=0", ackSeen); end
    dat[0] = 8'h77; dat[1] = 8'h88; drive_data();
    iReq = 2'b11;
    iRST_n = 1'b1;
    mPtr = 0;
    step();
    total++; if (oOwner !== OW'(0) || oTxD_DATA !== 8'h77) begin bad++; $display("FAIL rst_first owner=%0d data=%h exp 0/77", oOwner, oTxD_DATA); end
    mPtr = 1;
    step();
    iTxD_Done = 1'b1; step(); iTxD_Done = 1'b0;
    total++; if (oAck !== 2'b01) begin bad++; $display("FAIL rst_ack0 got=%b exp=01", oAck); end
    step();
    iReq = 2'b10;
    repeat (GAPC) step();
    total++; if (oOwner !== OW'(1) || oTxD_DATA !== 8'h88) begin bad++; $display("FAIL rst_second owner=%0d data=%h exp 1/88", oOwner, oTxD_DATA); end
    mPtr = 0;
    iTxD_Done = 1'b1; step(); iTxD_Done = 1'b0;
    total++; if (oAck !== 2'b10) begin bad++; $display("FAIL rst_ack1 got=%b exp=10", oAck); end
    iReq = '0;
    repeat (GAPC + 1) step();
  endtask

  task automatic test_random(input int iters);
    logic [NREQ-1:0] pend;
    int w, d, it;
    bit first, tmo;
    pend = '0; it = 0; first = 1'b1;
    while (it < iters || pend != '0) begin
      if (it < iters) begin
        for (int k = 0; k < NREQ; k++)
          if (!pend[k] && $urandom_range(0, 1) == 1) begin pend[k] = 1'b1; dat[k] = 8'($urandom); end
        if (pend == '0) begin
          int k;
          k = $urandom_range(0, NREQ - 1);
          pend[k] = 1'b1; dat[k] = 8'($urandom);
        end
        it++;
      end
      iReq = pend; drive_data();
      if (first) step();
      else begin
        repeat (GAPC - 1) step();
        total++; if (oTxD_Start !== 1'b0 || oBusy !== 1'b0) begin bad++; $display("FAIL rnd_idle%0d start=%b busy=%b exp 0/0", it, oTxD_Start, oBusy); end
        step();
      end
      first = 1'b0;
      w = rrPick(pend, mPtr); mPtr = (w + 1) % NREQ;
      total++; if (oTxD_Start !== 1'b1 || oOwner !== OW'(w) || oTxD_DATA !== dat[w]) begin
        bad++; $display("FAIL rnd_grant%0d start=%b owner=%0d data=%h exp 1/%0d/%h", it, oTxD_Start, oOwner, oTxD_DATA, w, dat[w]);
      end
      tmo = ($urandom_range(0, 4) == 0);
      if (tmo) begin
        repeat (TIMEOUT) step();
      end else begin
        d = $urandom_range(0, 30);
        repeat (d) step();
        total++; if (oTxD_Start !== 1'b1 || oAck !== '0) begin bad++; $display("FAIL rnd_send%0d start=%b ack=%b exp 1/00", it, oTxD_Start, oAck); end
        iTxD_Done = 1'b1; step(); iTxD_Done = 1'b0;
      end
      total++; if (oAck !== (NREQ'(1) << w) || oErr !== tmo || oTxD_Start !== 1'b0) begin
        bad++; $display("FAIL rnd_ack%0d ack=%b err=%b start=%b exp %b/%b/0", it, oAck, oErr, oTxD_Start, NREQ'(1) << w, tmo);
      end
      pend[w] = 1'b0;
      step();
      total++; if (oAck !== '0) begin bad++; $display("FAIL rnd_pulse%0d got=%b exp=00", it, oAck); end
    end
    iReq = '0;
    repeat (GAPC) step();
    total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL rnd_end_busy got=%b exp=0", oBusy); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_collision();
    test_data_change();
    test_reset_mid();
    test_random(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
